// File: rtl/ram_bus_pkg.sv
// Shared RamBus definitions: state encoding, default widths and the timeout fill value,
// for use by the initiator and by future responders and monitors.
package ram_bus_pkg;

  localparam int RAM_BUS_ADDR_WIDTH = 14;
  localparam int RAM_BUS_DATA_WIDTH = 32;

  localparam logic [RAM_BUS_DATA_WIDTH-1:0] RAM_BUS_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    RB_IDLE   = 2'd0,
    RB_SETUP  = 2'd1,
    RB_ACCESS = 2'd2,
    RB_RESP   = 2'd3
  } ram_bus_state_e;

  // A disabled timeout (0) still needs a 1-bit counter to keep the RTL legal.
  function automatic int ram_bus_cnt_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/ram_bus_if.sv
// Command, response and RamBus signals of the fabric-side initiator, grouped in one bundle.
interface ram_bus_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);

  logic                  CmdValid;
  logic                  CmdReady;
  logic                  CmdWrnRd;
  logic [ADDR_WIDTH-1:0] CmdAddress;
  logic [DATA_WIDTH-1:0] CmdData;

  logic                  RspValid;
  logic                  RspReady;
  logic [DATA_WIDTH-1:0] RspData;
  logic                  RspTimeout;
  logic                  RspWrnRd;

  logic                  RamBusnCs;
  logic                  RamBusWrnRd;
  logic                  RamBusLatch;
  logic [ADDR_WIDTH-1:0] RamBusAddress;
  logic [DATA_WIDTH-1:0] RamBusDataOut;
  logic [DATA_WIDTH-1:0] RamBusDataIn;
  logic                  RamBusAck;

  modport master (
    input  CmdValid, CmdWrnRd, CmdAddress, CmdData,
    output CmdReady,
    output RspValid, RspData, RspTimeout, RspWrnRd,
    input  RspReady,
    output RamBusnCs, RamBusWrnRd, RamBusLatch, RamBusAddress, RamBusDataOut,
    input  RamBusDataIn, RamBusAck
  );

  modport slave (
    output CmdValid, CmdWrnRd, CmdAddress, CmdData,
    input  CmdReady,
    input  RspValid, RspData, RspTimeout, RspWrnRd,
    output RspReady,
    input  RamBusnCs, RamBusWrnRd, RamBusLatch, RamBusAddress, RamBusDataOut,
    output RamBusDataIn, RamBusAck
  );

endinterface

// File: rtl/ram_bus_master.sv
// RamBus initiator: accepts one command at a time, runs a SETUP/ACCESS cycle with an
// ack timeout and returns read data or a timeout flag on the response channel.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = RAM_BUS_ADDR_WIDTH,
  parameter int                    DATA_WIDTH     = RAM_BUS_DATA_WIDTH,
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = DATA_WIDTH'(RAM_BUS_TIMEOUT_DATA)
) (
  input logic       clk,
  input logic       nReset,
  ram_bus_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'(RB_IDLE);
  localparam logic [1:0] S_SETUP  = 2'(RB_SETUP);
  localparam logic [1:0] S_ACCESS = 2'(RB_ACCESS);
  localparam logic [1:0] S_RESP   = 2'(RB_RESP);

  localparam int             CNT_W      = ram_bus_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W:0] CNT_LIMIT  = (CNT_W + 1)'(TIMEOUT_CYCLES);
  localparam bit             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W:0]        w_cnt_inc;
  logic                  w_cmd_hs;
  logic                  w_ack_hit;
  logic                  w_timeout_hit;

  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_timeout;
  logic                  r_rsp_wrnrd;
  logic                  r_cs;
  logic                  r_latch;
  logic                  r_wrnrd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  assign w_cmd_hs  = bus.CmdValid && r_cmd_ready;
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W + 1)'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_ack_hit     = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_hs) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        // Ack is checked first so an ack in the last permitted cycle beats the timeout.
        if (bus.RamBusAck) begin
          w_ack_hit   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (TIMEOUT_EN && (w_cnt_inc == CNT_LIMIT)) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.RspReady) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
      r_rsp_wrnrd   <= 1'b0;
      r_cs          <= 1'b0;
      r_latch       <= 1'b0;
      r_wrnrd       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      // Outputs are decoded from the next state so they line up with the state they describe.
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_cs        <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
      r_latch     <= (w_state_nxt == S_ACCESS);
      r_rsp_valid <= (w_state_nxt == S_RESP);

      if ((r_state == S_IDLE) && w_cmd_hs) begin
        r_addr  <= bus.CmdAddress;
        r_wdata <= bus.CmdData;
        r_wrnrd <= bus.CmdWrnRd;
        r_cnt   <= '0;
      end

      if ((r_state == S_ACCESS) && !w_ack_hit) r_cnt <= w_cnt_inc[CNT_W-1:0];

      if (w_ack_hit) begin
        r_rsp_data    <= r_wrnrd ? '0 : bus.RamBusDataIn;
        r_rsp_timeout <= 1'b0;
        r_rsp_wrnrd   <= r_wrnrd;
      end else if (w_timeout_hit) begin
        r_rsp_data    <= TIMEOUT_DATA;
        r_rsp_timeout <= 1'b1;
        r_rsp_wrnrd   <= r_wrnrd;
      end
    end
  end

  assign bus.CmdReady      = r_cmd_ready;
  assign bus.RspValid      = r_rsp_valid;
  assign bus.RspData       = r_rsp_data;
  assign bus.RspTimeout    = r_rsp_timeout;
  assign bus.RspWrnRd      = r_rsp_wrnrd;
  assign bus.RamBusnCs     = r_cs;
  assign bus.RamBusLatch   = r_latch;
  assign bus.RamBusWrnRd   = r_wrnrd;
  assign bus.RamBusAddress = r_addr;
  assign bus.RamBusDataOut = r_wdata;

endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
- Fabric-side initiator for the RamBus, which is the APB-style register bus that DMMainPorts responds on.
- Lets fabric logic (UART command parser, self-test sequencer, bench stimulus) drive DMMainPorts register reads and writes without the MSS.
- Takes one command at a time on a valid/ready interface, runs a SETUP/ACCESS bus cycle with an ack timeout, and returns read data or a timeout flag on a response interface.

Parameters:
- ADDR_WIDTH, 14, RamBus address width.
- DATA_WIDTH, 32, RamBus data width.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles spent waiting for RamBusAck; 0 disables the timeout.
- TIMEOUT_DATA, 32'hDEADBEEF, value returned on RspData when a transfer times out.

Ports:
- clk  in  1  system clock, same domain as DMMainPorts
- nReset  in  1  synchronous active-low reset
- CmdValid  in  1  command present
- CmdReady  out  1  command accepted when CmdValid and CmdReady are both high
- CmdWrnRd  in  1  1 = write, 0 = read
- CmdAddress  in  ADDR_WIDTH  register address
- CmdData  in  DATA_WIDTH  write data; ignored for reads
- RspValid  out  1  response present
- RspReady  in  1  response consumed when RspValid and RspReady are both high
- RspData  out  DATA_WIDTH  read data; 0 for writes; TIMEOUT_DATA on timeout
- RspTimeout  out  1  transfer aborted without ack
- RspWrnRd  out  1  echo of the command's CmdWrnRd
- RamBusnCs  out  1  select, active-high (APB PSEL semantics despite the name)
- RamBusWrnRd  out  1  PWRITE
- RamBusLatch  out  1  PENABLE
- RamBusAddress  out  ADDR_WIDTH  PADDR
- RamBusDataOut  out  DATA_WIDTH  PWDATA; drives the responder's RamBusDataIn
- RamBusDataIn  in  DATA_WIDTH  PRDATA; driven by the responder's RamBusDataOut
- RamBusAck  in  1  PREADY

Behaviour:
- One clock, clk. nReset is synchronous and active-low.
- Reset (nReset low at a rising edge) forces:
  - state IDLE;
  - all outputs 0, except CmdReady, which is 1 from the first edge after reset release.
  - Reset mid-transfer drops RamBusnCs and RamBusLatch on that same edge, with no response emitted.
- State machine, IDLE -> SETUP -> ACCESS -> RESP -> IDLE:
  - IDLE: CmdReady = 1. On a handshake, latch address, data and WrnRd into registers; go to SETUP.
  - SETUP, exactly 1 cycle: RamBusnCs = 1, RamBusLatch = 0, address/WrnRd/DataOut driven from the latched registers. Go to ACCESS.
  - ACCESS: RamBusnCs = 1, RamBusLatch = 1, bus outputs unchanged.
    - If RamBusAck is sampled high, capture RamBusDataIn for a read (0 for a write) and go to RESP with RspTimeout = 0.
    - Otherwise increment the wait counter. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, go to RESP with RspTimeout = 1 and RspData = TIMEOUT_DATA.
    - An ack in the final permitted cycle wins over the timeout.
  - RESP: RamBusnCs = 0, RamBusLatch = 0. RspValid = 1 and RspData/RspTimeout/RspWrnRd held stable until RspReady; then go to IDLE.
- CmdReady = 1 only in IDLE. No command is accepted while a response is pending.
- RamBusAddress, RamBusDataOut and RamBusWrnRd are registered and keep their last value after a transfer; only RamBusnCs and RamBusLatch return to 0.
- Latency:
  - handshake at edge T -> SETUP during T+1 -> ACCESS during T+2;
  - ack sampled at T+2 -> RspValid during T+3;
  - RspReady high at T+3 -> CmdReady during T+4.
  - Minimum command-to-command period is 4 cycles.
- Wait counter: width clog2(TIMEOUT_CYCLES+1), cleared on SETUP entry. RamBusAck is ignored outside ACCESS.
- All outputs are registered; no combinational path from RamBusAck to any output.

Decomposition:
- Package ram_bus_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - RAM_BUS_ADDR_WIDTH = 14 and RAM_BUS_DATA_WIDTH = 32;
  - TIMEOUT_DATA default.
- The package is shared with future RamBus responders and monitors.
- No sub-module: single FSM with the wait counter inline.

Test Plan:
- Write 0x0000_00A5 to 0x0010 against a responder that acks in its first ACCESS cycle -> RamBusnCs high for 2 cycles, RamBusLatch high for 1, RamBusWrnRd = 1; RspValid at T+3 with RspData = 0, RspTimeout = 0.
- Read 0x3FFF against a responder returning 0x1234_5678 with 3 wait states -> ACCESS lasts 4 cycles; RspData = 0x1234_5678, RspWrnRd = 0.
- Read with RamBusAck never asserted, TIMEOUT_CYCLES = 8 -> ACCESS lasts exactly 8 cycles; RspTimeout = 1, RspData = 0xDEADBEEF; bus select deasserted during RESP.
- Ack in ACCESS cycle 8 with TIMEOUT_CYCLES = 8 -> normal response, RspTimeout = 0.
- Back-to-back commands with CmdValid held high and RspReady tied high -> one transfer every 4 cycles. Hold RspReady low for 5 cycles -> CmdReady stays low and response fields stay stable.
- nReset asserted during ACCESS -> RamBusnCs and RamBusLatch are 0 on the next edge, no RspValid is produced, and CmdReady returns 1 on the first edge after release.
